pe_rs: RTL and testbench

//  Row-stationary processing element for the array; replaces the single-MAC PE wherever a

---
 rtl/pe_rs_pkg.sv | 26 ++
 rtl/pe_rs_mac.sv | 44 ++++
 rtl/pe_rs.sv | 241 ++++++++++++++++++++++++
 tb/tb_pe_rs.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_rs_pkg.sv
// Shared definitions for the row-stationary PE: FSM state encoding and width helpers.
package pe_rs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_FILT = 3'd1,
        ST_STREAM    = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_ACC       = 3'd4,
        ST_OUTPUT    = 3'd5,
        ST_DONE      = 3'd6
    } pe_state_e;

    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Wide enough to sum FILT_LEN full products plus one psum without overflow.
    function automatic int acc_width(input int bw, input int filt_len);
        return 2 * bw + clog2_int(filt_len) + 1;
    endfunction

endpackage

// File: rtl/pe_rs_mac.sv
// Registered multiply-accumulate holding the PE accumulator; supports clear and psum add.
module pe_rs_mac #(
    parameter int BITWIDTH = 16,
    parameter int ACC_W    = 35
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       clr_i,
    input  logic                       mac_en_i,
    input  logic [BITWIDTH-1:0]        a_i,
    input  logic [BITWIDTH-1:0]        b_i,
    input  logic                       add_en_i,
    input  logic [BITWIDTH-1:0]        add_data_i,
    output logic signed [ACC_W-1:0]    acc_o
);

    logic signed [2*BITWIDTH-1:0] prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      add_ext;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_d;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_W'(prod);
    assign add_ext  = ACC_W'($signed(add_data_i));

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else begin
            if (mac_en_i) acc_d = acc_d + prod_ext;
            if (add_en_i) acc_d = acc_d + add_ext;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_rs.sv
// Row-stationary PE: filter taps in a scratchpad, ifmap row through a sliding window,
// one saturated 1-D convolution psum per window, optional psum from the PE below.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; cfg latched on start
// LOAD_FILT | accepting L filter taps into the scratchpad
// STREAM    | accepting ifmap words into the window
// COMPUTE   | L cycles, one MAC per cycle over spad[k]*win[k]
// ACC       | waiting for the neighbour psum to add into the accumulator
// OUTPUT    | presenting the saturated psum until accepted
// DONE      | one-cycle done pulse
module pe_rs
    import pe_rs_pkg::*;
#(
    parameter int  BITWIDTH  = 16,
    parameter int  FILT_LEN  = 3,
    parameter int  FRAC_BITS = 0,
    localparam int LEN_W     = $clog2(FILT_LEN + 1)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                start,
    input  logic [LEN_W-1:0]    cfg_filt_len,
    input  logic                cfg_reload,
    input  logic                cfg_acc_in,
    output logic                busy,
    output logic                done,
    input  logic                filt_valid,
    output logic                filt_ready,
    input  logic [BITWIDTH-1:0] filt_data,
    input  logic                ifmap_valid,
    output logic                ifmap_ready,
    input  logic [BITWIDTH-1:0] ifmap_data,
    input  logic                ifmap_last,
    input  logic                psum_in_valid,
    output logic                psum_in_ready,
    input  logic [BITWIDTH-1:0] psum_in_data,
    output logic                psum_out_valid,
    input  logic                psum_out_ready,
    output logic [BITWIDTH-1:0] psum_out_data
);

    localparam int ACC_W = acc_width(BITWIDTH, FILT_LEN);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    pe_state_e           state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    fill_q, fill_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                acc_in_q, acc_in_d;
    logic                last_q, last_d;
    logic [BITWIDTH-1:0] spad_q [FILT_LEN];
    logic [BITWIDTH-1:0] win_q  [FILT_LEN];

    logic [LEN_W-1:0]    eff_len;
    logic [LEN_W-1:0]    len_m1;
    logic [LEN_W-1:0]    fill_inc;
    logic                spad_we;
    logic                win_shift;
    logic                mac_clr;
    logic                mac_en;
    logic                add_en;
    logic [BITWIDTH-1:0] mac_a;
    logic [BITWIDTH-1:0] mac_b;
    logic signed [ACC_W-1:0] mac_acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic [BITWIDTH-1:0] sat_val;

    always_comb begin
        eff_len = cfg_filt_len;
        if (cfg_filt_len == '0)                     eff_len = LEN_W'(1);
        else if (cfg_filt_len > LEN_W'(FILT_LEN))   eff_len = LEN_W'(FILT_LEN);
    end

    assign len_m1   = len_q - LEN_W'(1);
    assign fill_inc = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        fill_d         = fill_q;
        cnt_d          = cnt_q;
        acc_in_d       = acc_in_q;
        last_d         = last_q;
        busy           = (state_q != ST_IDLE);
        done           = 1'b0;
        filt_ready     = 1'b0;
        ifmap_ready    = 1'b0;
        psum_in_ready  = 1'b0;
        psum_out_valid = 1'b0;
        spad_we        = 1'b0;
        win_shift      = 1'b0;
        mac_clr        = 1'b0;
        mac_en         = 1'b0;
        add_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = eff_len;
                    acc_in_d = cfg_acc_in;
                    last_d   = 1'b0;
                    fill_d   = '0;
                    cnt_d    = '0;
                    state_d  = cfg_reload ? ST_LOAD_FILT : ST_STREAM;
                end
            end
            ST_LOAD_FILT: begin
                filt_ready = 1'b1;
                if (filt_valid) begin
                    spad_we = 1'b1;
                    if (cnt_q == len_m1) begin
                        cnt_d   = '0;
                        state_d = ST_STREAM;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                ifmap_ready = 1'b1;
                if (ifmap_valid) begin
                    win_shift = 1'b1;
                    last_d    = ifmap_last;
                    fill_d    = fill_inc;
                    if (fill_inc == len_q) begin
                        mac_clr = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_COMPUTE;
                    end else if (ifmap_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_COMPUTE: begin
                mac_en = 1'b1;
                if (cnt_q == len_m1) begin
                    cnt_d   = '0;
                    state_d = acc_in_q ? ST_ACC : ST_OUTPUT;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            ST_ACC: begin
                psum_in_ready = 1'b1;
                if (psum_in_valid) begin
                    add_en  = 1'b1;
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                psum_out_valid = 1'b1;
                if (psum_out_ready) state_d = last_q ? ST_DONE : ST_STREAM;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            len_q    <= LEN_W'(1);
            fill_q   <= '0;
            cnt_q    <= '0;
            acc_in_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            acc_in_q <= acc_in_d;
            last_q   <= last_d;
        end
    end

    // Newest word lands at win[L-1] so that win[k] holds x[n+k] for the current window.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < FILT_LEN; k++) begin
                spad_q[k] <= '0;
                win_q[k]  <= '0;
            end
        end else begin
            if (spad_we) begin
                for (int k = 0; k < FILT_LEN; k++)
                    if (LEN_W'(k) == cnt_q) spad_q[k] <= filt_data;
            end
            if (win_shift) begin
                for (int k = 0; k < FILT_LEN - 1; k++)
                    if (LEN_W'(k) < len_m1) win_q[k] <= win_q[k+1];
                for (int k = 0; k < FILT_LEN; k++)
                    if (LEN_W'(k) == len_m1) win_q[k] <= ifmap_data;
            end
        end
    end

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        for (int k = 0; k < FILT_LEN; k++) begin
            if (LEN_W'(k) == cnt_q) begin
                mac_a = spad_q[k];
                mac_b = win_q[k];
            end
        end
    end

    pe_rs_mac #(
        .BITWIDTH (BITWIDTH),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rstb       (rstb),
        .clr_i      (mac_clr),
        .mac_en_i   (mac_en),
        .a_i        (mac_a),
        .b_i        (mac_b),
        .add_en_i   (add_en),
        .add_data_i (psum_in_data),
        .acc_o      (mac_acc)
    );

    assign acc_sh = mac_acc >>> FRAC_BITS;

    always_comb begin
        sat_val = acc_sh[BITWIDTH-1:0];
        if (acc_sh > OUT_MAX)      sat_val = OUT_MAX[BITWIDTH-1:0];
        else if (acc_sh < OUT_MIN) sat_val = OUT_MIN[BITWIDTH-1:0];
    end

    assign psum_out_data = psum_out_valid ? sat_val : '0;

endmodule

// File: tb/tb_pe_rs.sv
// Bench for pe_rs: directed rows plus randomized rows checked against a behavioural
// convolution model (scratchpad image, per-window sums, saturation).
module tb_pe_rs;

    localparam int BW    = 16;
    localparam int FL    = 3;
    localparam int LEN_W = $clog2(FL + 1);

    logic             clk;
    logic             rstb;
    logic             start;
    logic [LEN_W-1:0] cfg_filt_len;
    logic             cfg_reload;
    logic             cfg_acc_in;
    logic             busy;
    logic             done;
    logic             filt_valid;
    logic             filt_ready;
    logic [BW-1:0]    filt_data;
    logic             ifmap_valid;
    logic             ifmap_ready;
    logic [BW-1:0]    ifmap_data;
    logic             ifmap_last;
    logic             psum_in_valid;
    logic             psum_in_ready;
    logic [BW-1:0]    psum_in_data;
    logic             psum_out_valid;
    logic             psum_out_ready;
    logic [BW-1:0]    psum_out_data;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     taps[$];
    int     xs[$];
    int     pins[$];
    longint m_spad[FL];
    int     stall_mode;

    pe_rs #(.BITWIDTH(BW), .FILT_LEN(FL), .FRAC_BITS(0)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .start          (start),
        .cfg_filt_len   (cfg_filt_len),
        .cfg_reload     (cfg_reload),
        .cfg_acc_in     (cfg_acc_in),
        .busy           (busy),
        .done           (done),
        .filt_valid     (filt_valid),
        .filt_ready     (filt_ready),
        .filt_data      (filt_data),
        .ifmap_valid    (ifmap_valid),
        .ifmap_ready    (ifmap_ready),
        .ifmap_data     (ifmap_data),
        .ifmap_last     (ifmap_last),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .psum_in_data   (psum_in_data),
        .psum_out_valid (psum_out_valid),
        .psum_out_ready (psum_out_ready),
        .psum_out_data  (psum_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32767;
            1:       return -32768;
            2:       return int'($urandom_range(0, 20)) - 10;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    task automatic idle_inputs();
        start          = 1'b0;
        filt_valid     = 1'b0;
        filt_data      = '0;
        ifmap_valid    = 1'b0;
        ifmap_data     = '0;
        ifmap_last     = 1'b0;
        psum_in_valid  = 1'b0;
        psum_in_data   = '0;
        psum_out_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " busy"}, longint'(busy), 0);
        chk({tag, " done"}, longint'(done), 0);
        chk({tag, " filt_ready"}, longint'(filt_ready), 0);
        chk({tag, " ifmap_ready"}, longint'(ifmap_ready), 0);
        chk({tag, " psum_in_ready"}, longint'(psum_in_ready), 0);
        chk({tag, " psum_out_valid"}, longint'(psum_out_valid), 0);
        chk({tag, " psum_out_data"}, longint'(psum_out_data), 0);
    endtask

    // Drives one row from taps/xs/pins and checks every psum against the model.
    task automatic run_row(input int len_cfg, input bit reload, input bit acc, input string tag);
        int     L, fi, xi, pi, nout, cyc, frdy, hold;
        bit     got_done, f_fire, x_fire, p_fire, o_fire;
        longint exp_list[$];
        longint s;
        L = (len_cfg == 0) ? 1 : ((len_cfg > FL) ? FL : len_cfg);
        if (reload) for (int k = 0; k < L; k++) m_spad[k] = taps[k];
        exp_list = {};
        for (int n = 0; n + L <= xs.size(); n++) begin
            s = 0;
            for (int k = 0; k < L; k++) s += m_spad[k] * longint'(xs[n+k]);
            if (acc) s += longint'(pins[n]);
            exp_list.push_back(sat16(s));
        end

        @(negedge clk);
        start        = 1'b1;
        cfg_filt_len = LEN_W'(len_cfg);
        cfg_reload   = reload;
        cfg_acc_in   = acc;
        @(negedge clk);
        start        = 1'b0;
        cfg_filt_len = LEN_W'($urandom);
        cfg_reload   = ~reload;
        cfg_acc_in   = ~acc;

        fi = 0; xi = 0; pi = 0; nout = 0; cyc = 0; frdy = 0; hold = 0; got_done = 0;
        while (!got_done && cyc < 500) begin
            filt_valid    = (fi < taps.size());
            filt_data     = filt_valid ? BW'(taps[fi]) : '0;
            ifmap_valid   = (xi < xs.size());
            ifmap_data    = ifmap_valid ? BW'(xs[xi]) : '0;
            ifmap_last    = (xi == xs.size() - 1);
            psum_in_valid = (pi < pins.size());
            psum_in_data  = psum_in_valid ? BW'(pins[pi]) : '0;
            case (stall_mode)
                0:       psum_out_ready = 1'b1;
                1:       psum_out_ready = 1'($urandom_range(0, 1));
                default: psum_out_ready = (nout > 0) || (hold >= 5);
            endcase
            #1;
            if (filt_ready) frdy++;
            if (psum_out_valid) begin
                if (nout < exp_list.size())
                    chk({tag, " psum"}, longint'($signed(psum_out_data)), exp_list[nout]);
                else
                    chk({tag, " extra psum index"}, nout, exp_list.size() - 1);
                if (!psum_out_ready) begin
                    hold++;
                    chk({tag, " ifmap_ready during hold"}, longint'(ifmap_ready), 0);
                end
            end
            if (done) got_done = 1;
            f_fire = filt_valid && filt_ready;
            x_fire = ifmap_valid && ifmap_ready;
            p_fire = psum_in_valid && psum_in_ready;
            o_fire = psum_out_valid && psum_out_ready;
            @(posedge clk);
            if (f_fire) fi++;
            if (x_fire) xi++;
            if (p_fire) pi++;
            if (o_fire) nout++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, " done seen"}, got_done, 1);
        chk({tag, " psum count"}, nout, exp_list.size());
        chk({tag, " ifmap consumed"}, xi, xs.size());
        if (reload) chk({tag, " taps loaded"}, fi, L);
        else        chk({tag, " filt_ready cycles"}, frdy, 0);
        if (acc)    chk({tag, " psum_in consumed"}, pi, exp_list.size());
        if (stall_mode == 2) chk({tag, " hold cycles"}, hold, 5);
        idle_inputs();
        #1;
        check_quiet({tag, " after done"});
    endtask

    initial begin
        int len_cfg, L, nx, xi, cyc;
        bit rl, ac, fire;

        idle_inputs();
        cfg_filt_len = '0;
        cfg_reload   = 1'b0;
        cfg_acc_in   = 1'b0;
        stall_mode   = 0;
        for (int k = 0; k < FL; k++) m_spad[k] = 0;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        rstb = 1'b1;

        taps = '{1, 2, 3}; xs = '{1, 2, 3, 4, 5}; pins = {};
        run_row(3, 1, 0, "t1");

        pins = '{100, 200, 300};
        run_row(3, 1, 1, "t2");

        pins = {}; stall_mode = 2;
        run_row(3, 1, 0, "t3");
        stall_mode = 0;

        taps = '{99, 99, 99}; xs = '{1, 1, 1};
        run_row(3, 0, 0, "t5");

        taps = '{32767, 32767, 32767}; xs = '{32767, 32767, 32767};
        run_row(3, 1, 0, "t4 pos");
        taps = '{-32768, -32768, -32768};
        run_row(3, 1, 0, "t4 neg");

        taps = {}; xs = '{7, 8};
        run_row(3, 0, 0, "t6");

        taps = '{5}; xs = '{1, -2, 3};
        run_row(0, 1, 0, "len0");

        // Abort a row with reset while the MAC is running.
        @(negedge clk);
        start = 1'b1; cfg_filt_len = LEN_W'(3); cfg_reload = 1'b0; cfg_acc_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ifmap_valid = 1'b1;
        xi = 0; cyc = 0;
        while (xi < 3 && cyc < 50) begin
            ifmap_data = BW'(xi + 5);
            #1;
            fire = ifmap_ready;
            @(posedge clk);
            if (fire) xi++;
            cyc++;
            @(negedge clk);
        end
        ifmap_valid = 1'b0;
        #1;
        chk("rst words accepted", xi, 3);
        chk("rst busy before", longint'(busy), 1);
        rstb = 1'b0;
        #1;
        check_quiet("mid reset");
        repeat (2) begin
            @(negedge clk);
            chk("mid reset done", longint'(done), 0);
        end
        rstb = 1'b1;
        for (int k = 0; k < FL; k++) m_spad[k] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post reset done", longint'(done), 0);
        end

        taps = {}; xs = '{4, 5, 6};
        run_row(3, 0, 0, "spad cleared");

        stall_mode = 1;
        for (int r = 0; r < 24; r++) begin
            len_cfg = $urandom_range(0, 3);
            L  = (len_cfg == 0) ? 1 : len_cfg;
            rl = 1'($urandom_range(0, 1));
            ac = 1'($urandom_range(0, 1));
            nx = $urandom_range(1, 7);
            taps = {}; xs = {}; pins = {};
            for (int k = 0; k < L; k++) taps.push_back(rnd_val());
            for (int n = 0; n < nx; n++) xs.push_back(rnd_val());
            if (ac) for (int n = 0; n + L <= nx; n++) pins.push_back(rnd_val());
            run_row(len_cfg, rl, ac, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
